// File: rtl/d_flip_flop.sv
// Parameterised D register: WIDTH bits, STAGES deep, synchronous reset to RST_VAL.
// Define DFF_QBAR_EN to add the separately registered complement output Yn.
module d_flip_flop #(
    parameter int               WIDTH   = 1,
    parameter int               STAGES  = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Y
`ifdef DFF_QBAR_EN
    ,
    output logic [WIDTH-1:0] Yn
`endif
);

    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
        $error("d_flip_flop: WIDTH=%0d outside 1..64", WIDTH);
    end

    if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
        $error("d_flip_flop: STAGES=%0d outside 1..8", STAGES);
    end

    logic [WIDTH-1:0] stage_q [STAGES];
    logic [WIDTH-1:0] stage_d [STAGES];

    // Reset overrides capture for every stage, discarding in-flight data.
    always_comb begin
        for (int i = 0; i < STAGES; i++) begin
            stage_d[i] = RST_VAL;
        end
        if (!reset) begin
            stage_d[0] = D;
            for (int i = 1; i < STAGES; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < STAGES; i++) begin
            stage_q[i] <= stage_d[i];
        end
    end

    assign Y = stage_q[STAGES-1];

`ifdef DFF_QBAR_EN
    logic [WIDTH-1:0] yn_q;
    logic [WIDTH-1:0] yn_d;

    // Own flop fed from the last stage's next value, so Yn tracks ~Y edge for edge.
    always_comb begin
        yn_d = ~stage_d[STAGES-1];
    end

    always_ff @(posedge clk) begin
        yn_q <= yn_d;
    end

    assign Yn = yn_q;
`endif

endmodule

// File: tb/tb_d_flip_flop.sv
// Bench for d_flip_flop: three configurations driven in parallel,
// table vectors, hand sequences and random traffic against a history model.
module tb_d_flip_flop;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] d = 8'h00;

    logic       ya;
    logic [7:0] yb;
    logic [3:0] yc;
`ifdef DFF_QBAR_EN
    logic       yna;
    logic [7:0] ynb;
    logic [3:0] ync;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    d_flip_flop u_a (
        .clk(clk), .reset(reset), .D(d[0]), .Y(ya)
`ifdef DFF_QBAR_EN
        , .Yn(yna)
`endif
    );

    d_flip_flop #(.WIDTH(8), .STAGES(1), .RST_VAL(8'hA5)) u_b (
        .clk(clk), .reset(reset), .D(d), .Y(yb)
`ifdef DFF_QBAR_EN
        , .Yn(ynb)
`endif
    );

    d_flip_flop #(.WIDTH(4), .STAGES(3), .RST_VAL(4'h9)) u_c (
        .clk(clk), .reset(reset), .D(d[3:0]), .Y(yc)
`ifdef DFF_QBAR_EN
        , .Yn(ync)
`endif
    );

    // Model: history of {reset, D} per edge, newest first.
    typedef struct {
        logic       rst;
        logic [7:0] d;
    } ev_t;
    ev_t hist[$];

    // Y after the latest edge is the D from STAGES edges back,
    // unless any of those STAGES edges was a reset.
    function automatic logic [7:0] model_y(int s, logic [7:0] mask,
                                           logic [7:0] rv);
        if (hist.size() < s) return rv;
        for (int i = 0; i < s; i++) begin
            if (hist[i].rst) return rv;
        end
        return hist[s-1].d & mask;
    endfunction

    task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    task automatic check_model();
        logic [7:0] ea, eb, ec;
        ea = model_y(1, 8'h01, 8'h00);
        eb = model_y(1, 8'hFF, 8'hA5);
        ec = model_y(3, 8'h0F, 8'h09);
        chk("a_y", 8'(ya), ea);
        chk("b_y", yb, eb);
        chk("c_y", 8'(yc), ec);
`ifdef DFF_QBAR_EN
        chk("a_yn", 8'(yna), 8'(~ea[0]));
        chk("b_yn", ynb, ~eb);
        chk("c_yn", 8'(ync), 8'(~ec[3:0]));
`endif
    endtask

    task automatic step(logic r, logic [7:0] v);
        ev_t e;
        reset = r;
        d = v;
        @(posedge clk);
        #2;
        e.rst = r;
        e.d = v;
        hist.push_front(e);
        if (hist.size() > 8) void'(hist.pop_back());
        check_model();
    endtask

    typedef struct {
        logic       rst;
        logic [7:0] d;
        logic       ea;
        logic [7:0] eb;
        logic [3:0] ec;
    } vec_t;
    vec_t tbl[11];

    logic [7:0] hold_b;
    logic [3:0] seq_d [6];
    logic [3:0] seq_e [6];

    initial begin
        tbl[0]  = '{1'b1, 8'hFF, 1'b0, 8'hA5, 4'h9};
        tbl[1]  = '{1'b1, 8'hFF, 1'b0, 8'hA5, 4'h9};
        tbl[2]  = '{1'b0, 8'h01, 1'b1, 8'h01, 4'h9};
        tbl[3]  = '{1'b0, 8'h3C, 1'b0, 8'h3C, 4'h9};
        tbl[4]  = '{1'b0, 8'h02, 1'b0, 8'h02, 4'h1};
        tbl[5]  = '{1'b0, 8'h03, 1'b1, 8'h03, 4'hC};
        tbl[6]  = '{1'b1, 8'hFF, 1'b0, 8'hA5, 4'h9};
        tbl[7]  = '{1'b0, 8'h0F, 1'b1, 8'h0F, 4'h9};
        tbl[8]  = '{1'b0, 8'h04, 1'b0, 8'h04, 4'h9};
        tbl[9]  = '{1'b0, 8'h05, 1'b1, 8'h05, 4'hF};
        tbl[10] = '{1'b0, 8'h06, 1'b0, 8'h06, 4'h4};

        @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].rst, tbl[i].d);
            chk($sformatf("tbl%0d_a", i), 8'(ya), 8'(tbl[i].ea));
            chk($sformatf("tbl%0d_b", i), yb, tbl[i].eb);
            chk($sformatf("tbl%0d_c", i), 8'(yc), 8'(tbl[i].ec));
`ifdef DFF_QBAR_EN
            chk($sformatf("tbl%0d_bn", i), ynb, ~tbl[i].eb);
`endif
        end

        // Y holds between edges while D toggles.
        hold_b = yb;
        d = 8'hC3;
        #2;
        d = 8'h5A;
        #1;
        chk("hold_b", yb, hold_b);

        // Pipeline fill after reset, then reset mid-stream.
        seq_d = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
        seq_e = '{4'h9, 4'h9, 4'h1, 4'h2, 4'h3, 4'h4};
        step(1'b1, 8'h00);
        chk("pipe_rst", 8'(yc), 8'h09);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 8'(seq_d[i]));
            chk($sformatf("pipe%0d", i), 8'(yc), 8'(seq_e[i]));
        end
        step(1'b1, 8'h07);
        chk("mid_rst", 8'(yc), 8'h09);
        step(1'b0, 8'h0A);
        chk("flush1", 8'(yc), 8'h09);
        step(1'b0, 8'h0B);
        chk("flush2", 8'(yc), 8'h09);
        step(1'b0, 8'h0C);
        chk("refill", 8'(yc), 8'h0A);

        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 7) == 0), 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
